// File: rtl/regfile_seq_fsm.sv
// regfile_seq_fsm: sequencer that fills a register file with a two-term
// recurrence (r[i] = r[i-1] +/- r[i-2]) starting from two seeds. It then
// dumps every register on rout_o, one register per cycle.
// Optional feature: define REGFSM_DISPLAY_EN to drive display_o as four
// active-low hex digits of rout_o, registered one cycle late. Without the
// macro, display_o is tied to all segments off.
module regfile_seq_fsm #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] seed0_i,
    input  logic [WIDTH-1:0] seed1_i,
    output logic [WIDTH-1:0] rout_o,
    output logic             rvalid_o,
    output logic [3:0]       state_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic [27:0]      display_o
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD0 = 4'd1;
    localparam logic [3:0] S_LOAD1 = 4'd2;
    localparam logic [3:0] S_READ  = 4'd3;
    localparam logic [3:0] S_EXEC  = 4'd4;
    localparam logic [3:0] S_WRITE = 4'd5;
    localparam logic [3:0] S_DUMP  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

    logic [3:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] seed0_q, seed0_d;
    logic [WIDTH-1:0] seed1_q, seed1_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] regs_q [NREGS];

    // Register-file write port, driven by the FSM.
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH:0]   sum;

    // Next-state logic: sequencing, operand latching, arithmetic and write control.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        seed0_d = seed0_q;
        seed1_d = seed1_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = res_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    seed0_d = seed0_i;
                    seed1_d = seed1_i;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD0;
                end
            end
            S_LOAD0: begin
                we      = 1'b1;
                waddr   = '0;
                wdata   = seed0_q;
                state_d = S_LOAD1;
            end
            S_LOAD1: begin
                we      = 1'b1;
                waddr   = IDX_ONE;
                wdata   = seed1_q;
                idx_d   = IDX_TWO;
                state_d = S_READ;
            end
            S_READ: begin
                a_d     = regs_q[idx_q - IDX_ONE];
                b_d     = regs_q[idx_q - IDX_TWO];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (mode_q) begin
                    res_d = a_q - b_q;
                    if (a_q < b_q) ovf_d = 1'b1;
                end else begin
                    res_d = sum[WIDTH-1:0];
                    if (sum[WIDTH]) ovf_d = 1'b1;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                we = 1'b1;
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_READ;
                end else begin
                    ptr_d   = '0;
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + IDX_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath state registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            seed0_q <= '0;
            seed1_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            seed0_q <= seed0_d;
            seed1_q <= seed1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    // Register file: single write port, fully cleared by reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: the array is reset because every register must read zero after reset; this keeps it out of RAM macros.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rout_o   = (state_q == S_DUMP || state_q == S_DONE) ? regs_q[ptr_q] : '0;
    assign rvalid_o = (state_q == S_DUMP);
    assign busy_o   = (state_q >= S_LOAD0) && (state_q <= S_DUMP);
    assign state_o  = state_q;
    assign ovf_o    = ovf_q;

`ifdef REGFSM_DISPLAY_EN
    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [31:0] rout_ext;
    logic [27:0] display_q;

    assign rout_ext = 32'(rout_o);

    // Display register: four digits of rout_o, most significant digit first.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            display_q <= 28'hFFFFFFF;
        end else begin
            display_q <= {hex_to_seg(rout_ext[15:12]), hex_to_seg(rout_ext[11:8]),
                          hex_to_seg(rout_ext[7:4]),   hex_to_seg(rout_ext[3:0])};
        end
    end

    assign display_o = display_q;
`else
    assign display_o = 28'hFFFFFFF;
`endif

endmodule
